// File: rtl/calc_req_sched.sv
// calc_req_sched: collects two-cycle commands from four request ports
// (a..d), queues valid ones per port and issues them to one shared ALU with
// round-robin arbitration. ALU responses are routed back to the originating
// port. Invalid commands and commands that arrive at a full queue are answered
// locally with a reject.
//
// Ports
//   c_clk, reset                   clock, synchronous active-high reset
//   reqcmd_x / reqtag_x            command and tag of port x (sampled in cycle C)
//   reqx_dataa_in                  operand 1 in cycle C, operand 2 in cycle C+1
//   out_respx/out_datax/out_tag_x  registered one-cycle response per port
//   alu_req_*                      issue channel (valid/ready, cmd, op1, op2, id)
//   alu_rsp_*                      response channel (valid/ready, code, data, id)
//   id = {port index (a=0..d=3), tag}
module calc_req_sched #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  reqcmd_a,
  input  logic [3:0]  reqcmd_b,
  input  logic [3:0]  reqcmd_c,
  input  logic [3:0]  reqcmd_d,
  input  logic [1:0]  reqtag_a,
  input  logic [1:0]  reqtag_b,
  input  logic [1:0]  reqtag_c,
  input  logic [1:0]  reqtag_d,
  input  logic [31:0] reqa_dataa_in,
  input  logic [31:0] reqb_dataa_in,
  input  logic [31:0] reqc_dataa_in,
  input  logic [31:0] reqd_dataa_in,
  output logic [1:0]  out_respa,
  output logic [1:0]  out_respb,
  output logic [1:0]  out_respc,
  output logic [1:0]  out_respd,
  output logic [31:0] out_dataa,
  output logic [31:0] out_datab,
  output logic [31:0] out_datac,
  output logic [31:0] out_datad,
  output logic [1:0]  out_tag_a,
  output logic [1:0]  out_tag_b,
  output logic [1:0]  out_tag_c,
  output logic [1:0]  out_tag_d,
  output logic        alu_req_valid,
  input  logic        alu_req_ready,
  output logic [3:0]  alu_req_cmd,
  output logic [31:0] alu_req_op1,
  output logic [31:0] alu_req_op2,
  output logic [3:0]  alu_req_id,
  input  logic        alu_rsp_valid,
  output logic        alu_rsp_ready,
  input  logic [1:0]  alu_rsp_code,
  input  logic [31:0] alu_rsp_data,
  input  logic [3:0]  alu_rsp_id
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  // Per-port views of the flat port list.
  logic [3:0]  cmd_in    [4];
  logic [1:0]  tag_in    [4];
  logic [31:0] dat_in    [4];
  logic [1:0]  resp_out  [4];
  logic [31:0] data_out  [4];
  logic [1:0]  tag_out   [4];
  entry_t      head      [4];

  logic [3:0]  fifo_nonempty;
  logic [3:0]  pop;
  logic [3:0]  reject_now;

  assign cmd_in[0] = reqcmd_a;
  assign cmd_in[1] = reqcmd_b;
  assign cmd_in[2] = reqcmd_c;
  assign cmd_in[3] = reqcmd_d;
  assign tag_in[0] = reqtag_a;
  assign tag_in[1] = reqtag_b;
  assign tag_in[2] = reqtag_c;
  assign tag_in[3] = reqtag_d;
  assign dat_in[0] = reqa_dataa_in;
  assign dat_in[1] = reqb_dataa_in;
  assign dat_in[2] = reqc_dataa_in;
  assign dat_in[3] = reqd_dataa_in;

  assign out_respa = resp_out[0];
  assign out_respb = resp_out[1];
  assign out_respc = resp_out[2];
  assign out_respd = resp_out[3];
  assign out_dataa = data_out[0];
  assign out_datab = data_out[1];
  assign out_datac = data_out[2];
  assign out_datad = data_out[3];
  assign out_tag_a = tag_out[0];
  assign out_tag_b = tag_out[1];
  assign out_tag_c = tag_out[2];
  assign out_tag_d = tag_out[3];

  // Arbitration and response-channel control
  logic [1:0] rr_ptr_reg;     // last granted port
  logic       lock_reg;       // a stalled offer is being held
  logic [1:0] lock_port_reg;
  logic       rst_d_reg;      // high in the cycle after a reset edge
  logic [1:0] rr_port;
  logic [1:0] sel_port;
  logic       req_en;
  logic       issue;
  logic [1:0] rsp_port;
  logic       rsp_fire;

  // Both channels stay quiet while reset is applied and for one cycle after.
  assign req_en = ~reset & ~rst_d_reg;

  always_comb begin
    rr_port = rr_ptr_reg;
    for (int i = 4; i >= 1; i--) begin
      // Descending scan so the closest port after the pointer wins last.
      if (fifo_nonempty[rr_ptr_reg + 2'(i)]) begin
        rr_port = rr_ptr_reg + 2'(i);
      end
    end
  end

  // Once offered and stalled, keep presenting the same port even if a port
  // with higher round-robin priority becomes non-empty in the meantime.
  assign sel_port      = lock_reg ? lock_port_reg : rr_port;
  assign alu_req_valid = req_en & (|fifo_nonempty);
  assign alu_req_cmd   = head[sel_port].cmd;
  assign alu_req_op1   = head[sel_port].op1;
  assign alu_req_op2   = head[sel_port].op2;
  assign alu_req_id    = {sel_port, head[sel_port].tag};
  assign issue         = alu_req_valid & alu_req_ready;

  // A local reject owns the target port's output register this cycle, so an
  // ALU response for that port is held off; other ports are unaffected.
  assign rsp_port      = alu_rsp_id[3:2];
  assign alu_rsp_ready = req_en & ~(alu_rsp_valid & reject_now[rsp_port]);
  assign rsp_fire      = alu_rsp_valid & alu_rsp_ready;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_ptr_reg    <= 2'd3;      // port a is searched first
      lock_reg      <= 1'b0;
      lock_port_reg <= 2'd0;
      rst_d_reg     <= 1'b1;
    end else begin
      rst_d_reg     <= 1'b0;
      lock_reg      <= alu_req_valid & ~alu_req_ready;
      lock_port_reg <= sel_port;
      if (issue) begin
        rr_ptr_reg <= sel_port;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    // Command capture (cycle C), completed by operand 2 in cycle C+1.
    logic             cap_pending_reg;
    logic [3:0]       cap_cmd_reg;
    logic [1:0]       cap_tag_reg;
    logic [31:0]      cap_op1_reg;
    // Queue
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             cmd_ok;
    logic             push;
    // Response register
    logic [1:0]       resp_reg;
    logic [1:0]       resp_next;
    logic [31:0]      data_reg;
    logic [31:0]      data_next;
    logic [1:0]       tag_reg;
    logic [1:0]       tag_next;

    assign cmd_ok = cap_cmd_reg inside {4'd1, 4'd2, 4'd5, 4'd6};
    // A pop at the same edge frees a slot for the incoming entry.
    assign push   = cap_pending_reg & cmd_ok & ((count_reg != FULL_CNT) | pop[gi]);
    assign reject_now[gi]    = cap_pending_reg & ~push;
    assign pop[gi]           = issue & (sel_port == 2'(gi));
    assign fifo_nonempty[gi] = (count_reg != '0);
    assign head[gi]          = mem[rd_ptr_reg];

    always_ff @(posedge c_clk) begin
      if (reset) begin
        cap_pending_reg <= 1'b0;
        cap_cmd_reg     <= 4'd0;
        cap_tag_reg     <= 2'd0;
        cap_op1_reg     <= 32'd0;
        wr_ptr_reg      <= '0;
        rd_ptr_reg      <= '0;
        count_reg       <= '0;
      end else begin
        if (cap_pending_reg) begin
          // Operand-2 cycle: reqcmd is not a new command here.
          cap_pending_reg <= 1'b0;
        end else if (cmd_in[gi] != 4'd0) begin
          cap_pending_reg <= 1'b1;
          cap_cmd_reg     <= cmd_in[gi];
          cap_tag_reg     <= tag_in[gi];
          cap_op1_reg     <= dat_in[gi];
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop[gi]) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop[gi]);
      end
    end

    // Queue storage carries no reset; occupancy is tracked by count_reg.
    always_ff @(posedge c_clk) begin
      if (!reset && push) begin
        mem[wr_ptr_reg] <= '{cmd: cap_cmd_reg, tag: cap_tag_reg,
                             op1: cap_op1_reg, op2: dat_in[gi]};
      end
    end

    always_comb begin
      resp_next = 2'd0;
      data_next = 32'd0;
      tag_next  = 2'd0;
      if (reject_now[gi]) begin
        resp_next = 2'd3;
        tag_next  = cap_tag_reg;
      end else if (rsp_fire && (rsp_port == 2'(gi))) begin
        resp_next = alu_rsp_code;
        data_next = alu_rsp_data;
        tag_next  = alu_rsp_id[1:0];
      end
    end

    always_ff @(posedge c_clk) begin
      if (reset) begin
        resp_reg <= 2'd0;
        data_reg <= 32'd0;
        tag_reg  <= 2'd0;
      end else begin
        resp_reg <= resp_next;
        data_reg <= data_next;
        tag_reg  <= tag_next;
      end
    end

    assign resp_out[gi] = resp_reg;
    assign data_out[gi] = data_reg;
    assign tag_out[gi]  = tag_reg;
  end

endmodule

// File: tb/tb_calc_req_sched.sv
// Directed bench for calc_req_sched. Single-command round trips are listed in
// a vector table; arbitration, back-pressure, reject/response collision and
// reset behaviour are covered by hand-written cycle sequences. The bench acts
// as the ALU itself, answering with the result values listed in the table.
module tb_calc_req_sched;

  logic             c_clk;
  logic             reset;
  logic [3:0][3:0]  cmd_v;
  logic [3:0][1:0]  tag_v;
  logic [3:0][31:0] din_v;
  logic [3:0][1:0]  resp_v;
  logic [3:0][31:0] dout_v;
  logic [3:0][1:0]  tout_v;
  logic             alu_req_valid;
  logic             alu_req_ready;
  logic [3:0]       alu_req_cmd;
  logic [31:0]      alu_req_op1;
  logic [31:0]      alu_req_op2;
  logic [3:0]       alu_req_id;
  logic             alu_rsp_valid;
  logic             alu_rsp_ready;
  logic [1:0]       alu_rsp_code;
  logic [31:0]      alu_rsp_data;
  logic [3:0]       alu_rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  calc_req_sched #(.FIFO_DEPTH(2)) dut (
    .c_clk(c_clk), .reset(reset),
    .reqcmd_a(cmd_v[0]), .reqcmd_b(cmd_v[1]), .reqcmd_c(cmd_v[2]), .reqcmd_d(cmd_v[3]),
    .reqtag_a(tag_v[0]), .reqtag_b(tag_v[1]), .reqtag_c(tag_v[2]), .reqtag_d(tag_v[3]),
    .reqa_dataa_in(din_v[0]), .reqb_dataa_in(din_v[1]),
    .reqc_dataa_in(din_v[2]), .reqd_dataa_in(din_v[3]),
    .out_respa(resp_v[0]), .out_respb(resp_v[1]), .out_respc(resp_v[2]), .out_respd(resp_v[3]),
    .out_dataa(dout_v[0]), .out_datab(dout_v[1]), .out_datac(dout_v[2]), .out_datad(dout_v[3]),
    .out_tag_a(tout_v[0]), .out_tag_b(tout_v[1]), .out_tag_c(tout_v[2]), .out_tag_d(tout_v[3]),
    .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
    .alu_req_cmd(alu_req_cmd), .alu_req_op1(alu_req_op1), .alu_req_op2(alu_req_op2),
    .alu_req_id(alu_req_id),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_ready(alu_rsp_ready),
    .alu_rsp_code(alu_rsp_code), .alu_rsp_data(alu_rsp_data), .alu_rsp_id(alu_rsp_id)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  alu_code;   // code the bench ALU answers with
    logic [31:0] alu_data;   // data the bench ALU answers with
    logic        exp_issue;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic next_cycle();
    @(posedge c_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge c_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                           input logic [31:0] dat);
    cmd_v[p] = cmd;
    tag_v[p] = tag;
    din_v[p] = dat;
  endtask

  // One command through the whole path, ALU ready throughout.
  task automatic run_vec(input vec_t v, input int idx);
    int p;
    p = v.port;
    next_cycle();                      // C
    drive_cmd(p, v.cmd, v.tag, v.op1);
    next_cycle();                      // C+1
    drive_cmd(p, 4'd0, 2'd0, v.op2);
    next_cycle();                      // C+2
    drive_cmd(p, 4'd0, 2'd0, 32'd0);
    sample();
    if (v.exp_issue) begin
      check($sformatf("v%0d issue valid", idx), alu_req_valid, 1'b1);
      check($sformatf("v%0d issue cmd", idx), alu_req_cmd, v.cmd);
      check($sformatf("v%0d issue op1", idx), alu_req_op1, v.op1);
      check($sformatf("v%0d issue op2", idx), alu_req_op2, v.op2);
      check($sformatf("v%0d issue id", idx), alu_req_id, {p[1:0], v.tag});
    end else begin
      check($sformatf("v%0d no issue", idx), alu_req_valid, 1'b0);
      check($sformatf("v%0d reject resp", idx), resp_v[p], v.exp_resp);
      check($sformatf("v%0d reject data", idx), dout_v[p], v.exp_data);
      check($sformatf("v%0d reject tag", idx), tout_v[p], v.tag);
    end
    next_cycle();                      // C+3
    if (v.exp_issue) begin
      alu_rsp_valid = 1'b1;
      alu_rsp_code  = v.alu_code;
      alu_rsp_data  = v.alu_data;
      alu_rsp_id    = {p[1:0], v.tag};
    end
    sample();
    if (v.exp_issue) check($sformatf("v%0d rsp_ready", idx), alu_rsp_ready, 1'b1);
    else             check($sformatf("v%0d reject 1 cycle", idx), resp_v[p], 2'd0);
    next_cycle();                      // C+4
    alu_rsp_valid = 1'b0;
    sample();
    if (v.exp_issue) begin
      check($sformatf("v%0d out resp", idx), resp_v[p], v.exp_resp);
      check($sformatf("v%0d out data", idx), dout_v[p], v.exp_data);
      check($sformatf("v%0d out tag", idx), tout_v[p], v.tag);
      next_cycle();                    // C+5
      sample();
      check($sformatf("v%0d out 1 cycle", idx), resp_v[p], 2'd0);
    end
    $display("vector %0d port %0d cmd %0d tag %0d done", idx, p, v.cmd, v.tag);
  endtask

  initial begin
    vecs[0] = '{0, 4'd1, 2'd1, 32'd5, 32'd7, 2'd1, 32'd12, 1'b1, 2'd1, 32'd12};
    vecs[1] = '{1, 4'd3, 2'd2, 32'd9, 32'd9, 2'd0, 32'd0, 1'b0, 2'd3, 32'd0};
    vecs[2] = '{2, 4'd2, 2'd3, 32'd10, 32'd3, 2'd1, 32'd7, 1'b1, 2'd1, 32'd7};
    vecs[3] = '{3, 4'd5, 2'd0, 32'd1, 32'd4, 2'd1, 32'd16, 1'b1, 2'd1, 32'd16};
    vecs[4] = '{0, 4'd6, 2'd2, 32'h8000_0000, 32'd1, 2'd1, 32'h4000_0000, 1'b1, 2'd1, 32'h4000_0000};
    vecs[5] = '{1, 4'd1, 2'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0, 1'b1, 2'd2, 32'd0};
    vecs[6] = '{2, 4'hF, 2'd1, 32'd1, 32'd1, 2'd0, 32'd0, 1'b0, 2'd3, 32'd0};
    vecs[7] = '{3, 4'd4, 2'd3, 32'd2, 32'd2, 2'd0, 32'd0, 1'b0, 2'd3, 32'd0};

    reset = 1'b1;
    cmd_v = '0;
    tag_v = '0;
    din_v = '0;
    alu_req_ready = 1'b0;
    alu_rsp_valid = 1'b0;
    alu_rsp_code  = 2'd0;
    alu_rsp_data  = 32'd0;
    alu_rsp_id    = 4'd0;

    // Reset state
    next_cycle();
    next_cycle();
    reset = 1'b0;
    sample();
    check("post-reset req_valid", alu_req_valid, 1'b0);
    check("post-reset rsp_ready", alu_rsp_ready, 1'b0);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("post-reset resp%0d", p), resp_v[p], 2'd0);
      check($sformatf("post-reset data%0d", p), dout_v[p], 32'd0);
    end
    next_cycle();
    sample();
    check("rsp_ready after reset", alu_rsp_ready, 1'b1);
    $display("reset state checked");

    // Table-driven single-command round trips
    alu_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // All four ports in the same cycle: issue a, b, c, d after a reset
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    for (int p = 0; p < 4; p++) drive_cmd(p, 4'd1, 2'd2, 32'(100 + p));
    next_cycle();
    for (int p = 0; p < 4; p++) drive_cmd(p, 4'd0, 2'd0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kp;
      kp = 2'(k);
      next_cycle();
      for (int p = 0; p < 4; p++) din_v[p] = 32'd0;
      sample();
      check($sformatf("rr slot%0d valid", k), alu_req_valid, 1'b1);
      check($sformatf("rr slot%0d id", k), alu_req_id, {kp, 2'd2});
      check($sformatf("rr slot%0d op1", k), alu_req_op1, 32'(100 + k));
      $display("round-robin slot %0d id %0h", k, alu_req_id);
    end
    next_cycle();
    sample();
    check("rr drained", alu_req_valid, 1'b0);

    // Back-pressure on port c: third command rejected, selection held
    alu_req_ready = 1'b0;
    next_cycle();                                   // T0
    drive_cmd(2, 4'd1, 2'd0, 32'd100);
    next_cycle();                                   // T1
    drive_cmd(2, 4'd0, 2'd0, 32'd1);
    next_cycle();                                   // T2
    drive_cmd(2, 4'd1, 2'd1, 32'd200);
    drive_cmd(0, 4'd1, 2'd3, 32'd300);
    sample();
    check("bp T2 valid", alu_req_valid, 1'b1);
    check("bp T2 id", alu_req_id, 4'h8);
    next_cycle();                                   // T3
    drive_cmd(2, 4'd0, 2'd0, 32'd2);
    drive_cmd(0, 4'd0, 2'd0, 32'd3);
    next_cycle();                                   // T4
    drive_cmd(2, 4'd1, 2'd2, 32'd400);
    din_v[0] = 32'd0;
    sample();
    check("bp T4 held id", alu_req_id, 4'h8);
    next_cycle();                                   // T5
    drive_cmd(2, 4'd0, 2'd0, 32'd4);
    sample();
    check("bp T5 no resp", resp_v[2], 2'd0);
    next_cycle();                                   // T6
    din_v[2] = 32'd0;
    alu_req_ready = 1'b1;
    sample();
    check("bp reject resp", resp_v[2], 2'd3);
    check("bp reject tag", tout_v[2], 2'd2);
    check("bp reject data", dout_v[2], 32'd0);
    check("bp T6 id", alu_req_id, 4'h8);
    check("bp T6 op1", alu_req_op1, 32'd100);
    next_cycle();                                   // T7
    sample();
    check("bp T7 id", alu_req_id, 4'h3);
    next_cycle();                                   // T8
    sample();
    check("bp T8 id", alu_req_id, 4'h9);
    check("bp T8 op1", alu_req_op1, 32'd200);
    next_cycle();                                   // T9
    sample();
    check("bp drained", alu_req_valid, 1'b0);
    $display("back-pressure sequence done");

    // Reject and ALU response collide on port d
    next_cycle();                                   // D0
    drive_cmd(3, 4'd1, 2'd1, 32'd40);
    next_cycle();                                   // D1
    drive_cmd(3, 4'd0, 2'd0, 32'd2);
    next_cycle();                                   // D2
    drive_cmd(3, 4'd7, 2'd3, 32'd99);
    sample();
    check("coll issue valid", alu_req_valid, 1'b1);
    check("coll issue id", alu_req_id, 4'hD);
    next_cycle();                                   // D3
    drive_cmd(3, 4'd0, 2'd0, 32'd0);
    alu_rsp_valid = 1'b1;
    alu_rsp_code  = 2'd1;
    alu_rsp_data  = 32'd42;
    alu_rsp_id    = 4'hD;
    sample();
    check("coll rsp_ready low", alu_rsp_ready, 1'b0);
    next_cycle();                                   // D4
    sample();
    check("coll reject resp", resp_v[3], 2'd3);
    check("coll reject tag", tout_v[3], 2'd3);
    check("coll reject data", dout_v[3], 32'd0);
    check("coll rsp_ready high", alu_rsp_ready, 1'b1);
    next_cycle();                                   // D5
    alu_rsp_valid = 1'b0;
    sample();
    check("coll alu resp", resp_v[3], 2'd1);
    check("coll alu data", dout_v[3], 32'd42);
    check("coll alu tag", tout_v[3], 2'd1);
    next_cycle();                                   // D6
    sample();
    check("coll quiet", resp_v[3], 2'd0);
    $display("collision sequence done");

    // Reset with two queued entries and a command mid-capture
    next_cycle();                                   // E0
    alu_req_ready = 1'b0;
    drive_cmd(0, 4'd1, 2'd0, 32'd1);
    next_cycle();                                   // E1
    drive_cmd(0, 4'd0, 2'd0, 32'd1);
    next_cycle();                                   // E2
    drive_cmd(0, 4'd1, 2'd1, 32'd2);
    sample();
    check("rst queued valid", alu_req_valid, 1'b1);
    next_cycle();                                   // E3
    drive_cmd(0, 4'd0, 2'd0, 32'd2);
    next_cycle();                                   // E4
    din_v[0] = 32'd0;
    drive_cmd(1, 4'd1, 2'd1, 32'd7);
    next_cycle();                                   // E5
    drive_cmd(1, 4'd0, 2'd0, 32'd8);
    reset = 1'b1;
    sample();
    check("rst during valid", alu_req_valid, 1'b0);
    check("rst during rsp_ready", alu_rsp_ready, 1'b0);
    next_cycle();                                   // E6
    reset = 1'b0;
    din_v[1] = 32'd0;
    alu_req_ready = 1'b1;
    sample();
    check("rst after valid", alu_req_valid, 1'b0);
    check("rst after rsp_ready", alu_rsp_ready, 1'b0);
    check("rst after resp b", resp_v[1], 2'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      check($sformatf("rst flushed valid%0d", k), alu_req_valid, 1'b0);
      check($sformatf("rst no resp a%0d", k), resp_v[0], 2'd0);
      check($sformatf("rst no resp b%0d", k), resp_v[1], 2'd0);
    end
    $display("reset flush sequence done");
    run_vec('{0, 4'd1, 2'd2, 32'd20, 32'd22, 2'd1, 32'd42, 1'b1, 2'd1, 32'd42}, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
